axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
//   Shares the single AXI read channel (AR/R) of the core's top-level AXI master between
//   the instruction fetch path and the data memory path. Requesters issue one burst read
//   each; the block issues one AXI transaction at a time and steers R beats back to the owner.
//   It sits between the I-cache/D-cache miss units and the top-level ar*/r* ports.
// PARAMETERS
//   STARVE_LIMIT  4   consecutive data grants while inst waits before inst is forced to win (>=1)
//   INST_ID       0   4-bit arid used for inst transactions
//   DATA_ID       1   4-bit arid used for data transactions
// PORTS
//   aclk          in   1   clock
//   aresetn       in   1   asynchronous active-low reset
//   inst_req      in   1   inst read request; held high until inst_ack
//   inst_addr     in   32  inst burst start address
//   inst_len      in   8   inst AXI len (beats-1)
//   inst_size     in   3   inst AXI size
//   inst_ack      out  1   1-cycle pulse: inst request latched
//   inst_rvalid   out  1   inst read beat valid
//   inst_rdata    out  32  inst read beat data
//   inst_rlast    out  1   last inst beat
//   inst_rerr     out  1   rresp!=0 on this inst beat
//   data_req/data_addr/data_len/data_size/data_ack/data_rvalid/data_rdata/data_rlast/data_rerr
//                 same as inst_* for the data requester
//   arid/araddr/arlen/arsize  out 4/32/8/3  AXI AR payload
//   arburst/arlock/arcache/arprot  out 2/2/4/3  constant 2'b01/0/0/0
//   arvalid       out  1   AXI AR valid
//   arready       in   1   AXI AR ready
//   rid/rdata/rresp  in  4/32/2  AXI R payload
//   rlast/rvalid  in   1/1 AXI R last/valid
//   rready        out  1   AXI R ready
// BEHAVIOUR
//   Reset (aresetn=0, async): state=IDLE, owner=inst, starve_cnt=0, arvalid=0, rready=0,
//     all *_ack/*_rvalid/*_rlast/*_rerr=0, araddr/arlen/arsize/arid=0.
//   FSM IDLE -> AR -> R -> IDLE; exactly one transaction outstanding.
//   IDLE: if any req: pick winner, latch addr/len/size/id into AR regs, pulse winner's ack
//     for that cycle (combinational from state==IDLE & grant), next state AR. No req: stay.
//   Arbitration: data wins over inst, except inst wins when both req and starve_cnt==STARVE_LIMIT.
//     starve_cnt: +1 on data grant while inst_req=1 (saturates at STARVE_LIMIT);
//     cleared on any inst grant; unchanged on data grant with inst_req=0.
//   AR: arvalid=1 (registered), payload stable; on arvalid&arready -> R next cycle. arvalid
//     never drops before arready.
//   R: rready=1 (registered). Each rvalid beat forwarded combinationally to owner only:
//     owner_rvalid=rvalid, owner_rdata=rdata, owner_rlast=rlast, owner_rerr=(rresp!=0).
//     Non-owner rvalid stays 0. On rvalid&rlast -> IDLE; rready=0 next cycle.
//   Earliest re-grant: the cycle after the rlast beat (IDLE); no AR/R overlap.
//   rid is not used for steering; rid!=latched arid is ignored (owner still receives beat).
//   Requests arriving during AR/R are held by requester and arbitrated on return to IDLE.
//   req dropped before ack: not latched, no transaction. req held after ack: treated as new.
//   Reset mid-transaction: FSM returns to IDLE asynchronously; outputs to reset values;
//     the interconnect is reset together with the core.
//   Latency: req in IDLE -> arvalid at next cycle; rvalid beat -> owner beat same cycle.
// TESTING
//   inst_req only, addr=0xBFC00000 len=7 size=2, arready=1 -> inst_ack cycle 0, arvalid
//     cycle 1 with arid=0 araddr=0xBFC00000 arlen=7; 8 beats to inst, inst_rlast on 8th.
//   Both req same cycle, starve_cnt=0 -> data_ack, arid=1; inst_ack only after data rlast
//     and return to IDLE.
//   data_req held continuously with inst_req=1 -> 4 data grants, 5th grant is inst
//     (STARVE_LIMIT=4); starve_cnt reads 0 after inst grant.
//   arready held low 10 cycles -> arvalid/araddr stable all 10 cycles; R entered only
//     after arready=1.
//   rresp=2'b10 on beat 2 of 4 -> owner_rerr=1 on that beat only; other rvalid stays 0.
//   aresetn low during beat 3 of 8 -> arvalid=rready=0 immediately; after release, new
//     inst_req granted normally from IDLE.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// Requester and AXI read-channel bundle shared by the arbiter and its environment.
interface axi_read_arbiter_if;
   // instruction requester
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [7:0]  inst_len;
   logic [2:0]  inst_size;
   logic        inst_ack;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        inst_rlast;
   logic        inst_rerr;
   // data requester
   logic        data_req;
   logic [31:0] data_addr;
   logic [7:0]  data_len;
   logic [2:0]  data_size;
   logic        data_ack;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_rlast;
   logic        data_rerr;
   // AXI AR channel
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   // AXI R channel
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   // arbiter side: owns acks, beat forwarding, AR payload and rready
   modport master (
      input  inst_req, inst_addr, inst_len, inst_size,
      output inst_ack, inst_rvalid, inst_rdata, inst_rlast, inst_rerr,
      input  data_req, data_addr, data_len, data_size,
      output data_ack, data_rvalid, data_rdata, data_rlast, data_rerr,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   // environment side: requesters plus the AXI slave
   modport slave (
      output inst_req, inst_addr, inst_len, inst_size,
      input  inst_ack, inst_rvalid, inst_rdata, inst_rlast, inst_rerr,
      output data_req, data_addr, data_len, data_size,
      input  data_ack, data_rvalid, data_rdata, data_rlast, data_rerr,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between instruction fetch and data paths,
// one transaction at a time, with starvation protection for instruction fetch.
module axi_read_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [3:0]  INST_ID      = 4'd0,
   parameter logic [3:0]  DATA_ID      = 4'd1
) (
   input logic                 aclk,
   input logic                 aresetn,
   axi_read_arbiter_if.master  bus
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, AR, R} state_t;
   typedef enum logic {OWN_INST, OWN_DATA} owner_t;

   state_t            state, state_d;
   owner_t            owner, owner_d;
   logic [CNT_W-1:0]  starve_cnt, starve_cnt_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic [3:0]        arid_q, arid_d;
   logic [31:0]       araddr_q, araddr_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [2:0]        arsize_q, arsize_d;

   logic at_limit;
   logic grant_data;
   logic grant_inst;
   logic beat;

   // Data normally wins; a waiting inst wins once data has starved it long enough.
   assign at_limit   = (starve_cnt == CNT_W'(STARVE_LIMIT));
   assign grant_data = bus.data_req & ~(bus.inst_req & at_limit);
   assign grant_inst = bus.inst_req & ~grant_data;
   assign beat       = (state == R) & rready_q & bus.rvalid;

   // State and registered AR/R control.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         owner      <= OWN_INST;
         starve_cnt <= '0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         arid_q     <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
      end else begin
         state      <= state_d;
         owner      <= owner_d;
         starve_cnt <= starve_cnt_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         arid_q     <= arid_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arsize_q   <= arsize_d;
      end
   end

   // Next-state: grant and latch in IDLE, hold AR until accepted, drain R until rlast.
   always_comb begin
      state_d      = state;
      owner_d      = owner;
      starve_cnt_d = starve_cnt;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      arid_d       = arid_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arsize_d     = arsize_q;
      case (state)
         IDLE: begin
            if (grant_data) begin
               state_d   = AR;
               owner_d   = OWN_DATA;
               arvalid_d = 1'b1;
               arid_d    = DATA_ID;
               araddr_d  = bus.data_addr;
               arlen_d   = bus.data_len;
               arsize_d  = bus.data_size;
               if (bus.inst_req && !at_limit) begin
                  starve_cnt_d = starve_cnt + CNT_W'(1);
               end
            end else if (grant_inst) begin
               state_d      = AR;
               owner_d      = OWN_INST;
               arvalid_d    = 1'b1;
               arid_d       = INST_ID;
               araddr_d     = bus.inst_addr;
               arlen_d      = bus.inst_len;
               arsize_d     = bus.inst_size;
               starve_cnt_d = '0;
            end
         end
         AR: begin
            if (bus.arready) begin
               state_d   = R;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         R: begin
            if (beat && bus.rlast) begin
               state_d  = IDLE;
               rready_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase
   end

   // Acks pulse in the granting cycle itself.
   assign bus.inst_ack = (state == IDLE) & grant_inst;
   assign bus.data_ack = (state == IDLE) & grant_data;

   // AR payload; burst type INCR, no lock/cache/prot attributes.
   assign bus.arid    = arid_q;
   assign bus.araddr  = araddr_q;
   assign bus.arlen   = arlen_q;
   assign bus.arsize  = arsize_q;
   assign bus.arvalid = arvalid_q;
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'b0000;
   assign bus.arprot  = 3'b000;
   assign bus.rready  = rready_q;

   // R beats steered to the latched owner only; rid plays no part in steering.
   assign bus.inst_rvalid = beat & (owner == OWN_INST);
   assign bus.inst_rdata  = (owner == OWN_INST) ? bus.rdata : '0;
   assign bus.inst_rlast  = beat & (owner == OWN_INST) & bus.rlast;
   assign bus.inst_rerr   = beat & (owner == OWN_INST) & (bus.rresp != 2'b00);
   assign bus.data_rvalid = beat & (owner == OWN_DATA);
   assign bus.data_rdata  = (owner == OWN_DATA) ? bus.rdata : '0;
   assign bus.data_rlast  = beat & (owner == OWN_DATA) & bus.rlast;
   assign bus.data_rerr   = beat & (owner == OWN_DATA) & (bus.rresp != 2'b00);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed scenarios plus random transactions
// checked against a transaction-level arbitration model.
module tb_axi_read_arbiter;

   localparam int unsigned LIMIT = 4;

   logic aclk = 1'b0;
   logic aresetn;
   int   checks   = 0;
   int   failures = 0;
   int   m_starve = 0;

   logic [31:0] ia, da;
   logic [7:0]  il, dl;
   logic [2:0]  is, ds;

   axi_read_arbiter_if bus ();

   axi_read_arbiter #(
      .STARVE_LIMIT (LIMIT),
      .INST_ID      (4'd0),
      .DATA_ID      (4'd1)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction from an IDLE cycle: request, AR phase, R beats.
   task automatic txn(input bit ireq, input bit dreq, input bit keep_data,
                      input int ar_wait, input int err_beat);
      bit          w_data;
      logic [31:0] ea;
      logic [7:0]  el;
      logic [2:0]  es;
      logic [3:0]  eid;
      logic [31:0] rd;
      logic [1:0]  rr;
      int          n;
      bus.inst_addr = ia; bus.inst_len = il; bus.inst_size = is;
      bus.data_addr = da; bus.data_len = dl; bus.data_size = ds;
      bus.inst_req  = ireq;
      bus.data_req  = dreq;
      w_data = dreq && !(ireq && m_starve == LIMIT);
      ea  = w_data ? da : ia;
      el  = w_data ? dl : il;
      es  = w_data ? ds : is;
      eid = w_data ? 4'd1 : 4'd0;
      @(negedge aclk);
      chk("idle_arvalid", 32'(bus.arvalid), 32'd0);
      chk("idle_rready", 32'(bus.rready), 32'd0);
      chk("inst_ack", 32'(bus.inst_ack), 32'(!w_data));
      chk("data_ack", 32'(bus.data_ack), 32'(w_data));
      if (!w_data) m_starve = 0;
      else if (ireq && m_starve < LIMIT) m_starve++;
      @(posedge aclk); #1;
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
      if (w_data && !keep_data) bus.data_req = 1'b0;
      if (!w_data) bus.inst_req = 1'b0;
      for (int i = 0; i <= ar_wait; i++) begin
         bus.arready = (i == ar_wait);
         @(negedge aclk);
         chk("arvalid", 32'(bus.arvalid), 32'd1);
         chk("araddr", bus.araddr, ea);
         chk("arlen", 32'(bus.arlen), 32'(el));
         chk("arsize", 32'(bus.arsize), 32'(es));
         chk("arid", 32'(bus.arid), 32'(eid));
         chk("ar_rready", 32'(bus.rready), 32'd0);
         chk("ar_acks", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
         @(posedge aclk); #1;
      end
      bus.arready = 1'b0;
      n = int'(el) + 1;
      for (int b = 0; b < n; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.rvalid = 1'b0;
            @(negedge aclk);
            chk("gap_rvalid", 32'({bus.inst_rvalid, bus.data_rvalid}), 32'd0);
            chk("gap_rready", 32'(bus.rready), 32'd1);
            @(posedge aclk); #1;
         end
         rd = $urandom;
         rr = (b == err_beat) ? 2'b10 : 2'b00;
         bus.rvalid = 1'b1;
         bus.rdata  = rd;
         bus.rresp  = rr;
         bus.rlast  = (b == n - 1);
         bus.rid    = 4'($urandom);
         @(negedge aclk);
         chk("r_rready", 32'(bus.rready), 32'd1);
         chk("r_arvalid", 32'(bus.arvalid), 32'd0);
         if (w_data) begin
            chk("data_rvalid", 32'(bus.data_rvalid), 32'd1);
            chk("data_rdata", bus.data_rdata, rd);
            chk("data_rlast", 32'(bus.data_rlast), 32'(b == n - 1));
            chk("data_rerr", 32'(bus.data_rerr), 32'(rr != 2'b00));
            chk("inst_rvalid_idle", 32'(bus.inst_rvalid), 32'd0);
         end else begin
            chk("inst_rvalid", 32'(bus.inst_rvalid), 32'd1);
            chk("inst_rdata", bus.inst_rdata, rd);
            chk("inst_rlast", 32'(bus.inst_rlast), 32'(b == n - 1));
            chk("inst_rerr", 32'(bus.inst_rerr), 32'(rr != 2'b00));
            chk("data_rvalid_idle", 32'(bus.data_rvalid), 32'd0);
         end
         @(posedge aclk); #1;
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
   endtask

   initial begin
      bit ireq, dreq;
      aresetn = 1'b0;
      bus.inst_req = 0; bus.inst_addr = 0; bus.inst_len = 0; bus.inst_size = 0;
      bus.data_req = 0; bus.data_addr = 0; bus.data_len = 0; bus.data_size = 0;
      bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0;
      bus.rlast = 0; bus.rvalid = 0;
      ia = 0; il = 0; is = 0; da = 0; dl = 0; ds = 0;

      // reset values
      #12;
      chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
      chk("rst_rready", 32'(bus.rready), 32'd0);
      chk("rst_araddr", bus.araddr, 32'd0);
      chk("rst_arlen", 32'(bus.arlen), 32'd0);
      chk("rst_arsize", 32'(bus.arsize), 32'd0);
      chk("rst_arid", 32'(bus.arid), 32'd0);
      chk("rst_arburst", 32'(bus.arburst), 32'd1);
      chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
      aresetn = 1'b1;
      @(posedge aclk); #1;

      // no request: nothing issued
      @(negedge aclk);
      chk("noreq_acks", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
      @(posedge aclk); #1;
      chk("noreq_arvalid", 32'(bus.arvalid), 32'd0);

      // boot fetch: inst only
      ia = 32'hBFC0_0000; il = 8'd7; is = 3'd2;
      txn(1'b1, 1'b0, 1'b0, 0, 99);

      // simultaneous requests: data first, inst afterwards
      ia = 32'h0000_1000; il = 8'd3; is = 3'd2;
      da = 32'h8000_0040; dl = 8'd1; ds = 3'd2;
      txn(1'b1, 1'b1, 1'b0, 0, 99);
      txn(1'b1, 1'b0, 1'b0, 1, 99);

      // data held continuously: inst forced through after LIMIT data grants
      ia = 32'h0000_2000; il = 8'd0; is = 3'd2;
      da = 32'h8000_1000; dl = 8'd0; ds = 3'd2;
      for (int k = 0; k <= int'(LIMIT); k++) txn(1'b1, 1'b1, 1'b1, 0, 99);
      txn(1'b0, 1'b1, 1'b0, 0, 99);

      // long arready stall
      da = 32'h8000_2000; dl = 8'd2; ds = 3'd1;
      txn(1'b0, 1'b1, 1'b0, 10, 99);

      // error response on beat 2 of 4
      ia = 32'h0000_3000; il = 8'd3; is = 3'd2;
      txn(1'b1, 1'b0, 1'b0, 0, 1);

      // reset during beat 3 of 8
      ia = 32'h0000_4000; il = 8'd7; is = 3'd2;
      bus.inst_addr = ia; bus.inst_len = il; bus.inst_size = is;
      bus.inst_req = 1'b1;
      @(negedge aclk);
      chk("rst_txn_ack", 32'(bus.inst_ack), 32'd1);
      @(posedge aclk); #1;
      bus.inst_req = 1'b0;
      bus.arready  = 1'b1;
      @(negedge aclk);
      chk("rst_txn_arvalid", 32'(bus.arvalid), 32'd1);
      @(posedge aclk); #1;
      bus.arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bus.rvalid = 1'b1; bus.rdata = $urandom; bus.rlast = 1'b0;
         @(negedge aclk);
         chk("rst_txn_beat", 32'(bus.inst_rvalid), 32'd1);
         @(posedge aclk); #1;
      end
      bus.rvalid = 1'b1;
      #1;
      chk("pre_rst_beat", 32'(bus.inst_rvalid), 32'd1);
      aresetn = 1'b0;
      #1;
      chk("midrst_arvalid", 32'(bus.arvalid), 32'd0);
      chk("midrst_rready", 32'(bus.rready), 32'd0);
      chk("midrst_rvalid", 32'(bus.inst_rvalid), 32'd0);
      chk("midrst_araddr", bus.araddr, 32'd0);
      bus.rvalid = 1'b0;
      m_starve = 0;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk); #1;
      ia = 32'h0000_5000; il = 8'd1; is = 3'd2;
      txn(1'b1, 1'b0, 1'b0, 0, 99);

      // random traffic; a losing requester keeps its request and payload
      for (int t = 0; t < 40; t++) begin
         if (!bus.inst_req) begin
            ia = $urandom; il = 8'($urandom_range(0, 5)); is = 3'($urandom_range(0, 2));
         end
         if (!bus.data_req) begin
            da = $urandom; dl = 8'($urandom_range(0, 5)); ds = 3'($urandom_range(0, 2));
         end
         ireq = bus.inst_req ? 1'b1 : 1'($urandom_range(0, 1));
         dreq = bus.data_req ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         if (!ireq && !dreq) begin
            @(negedge aclk);
            chk("rnd_idle_acks", 32'({bus.inst_ack, bus.data_ack}), 32'd0);
            @(posedge aclk); #1;
         end else begin
            txn(ireq, dreq, 1'b0, $urandom_range(0, 3), $urandom_range(0, 7));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
